cv_spinner_quad: RTL

//  Converts the framework spinner event stream (spinner_N, 9 bit) into the two-phase quadrature

---
 rtl/cv_spinner_quad_if.sv | 22 ++
 rtl/cv_spinner_quad.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/cv_spinner_quad_if.sv
// Spinner/quadrature bundle between the framework driver and cv_spinner_quad.
// master: framework side (drives the event stream, pacing and enable).
// slave:  the converter itself.
interface cv_spinner_quad_if;
    logic       ce_i;
    logic       enable_i;
    logic [8:0] spinner_i;
    logic [1:0] quad_o;
    logic       step_o;
    logic       dir_o;
    logic       pending_o;

    modport master (
        output ce_i, enable_i, spinner_i,
        input  quad_o, step_o, dir_o, pending_o
    );

    modport slave (
        input  ce_i, enable_i, spinner_i,
        output quad_o, step_o, dir_o, pending_o
    );
endinterface

// File: rtl/cv_spinner_quad.sv
// cv_spinner_quad: turns framework spinner events (9-bit toggle + signed delta)
// into paced active-low two-phase quadrature for a ColecoVision wheel port.
// Host deltas are buffered in a saturating signed accumulator and replayed one
// quadrature step at a time, at most once every STEP_DIV ce_i ticks.
// Optional macro CV_SPIN_ACCEL_EN: shorten the step interval while a large
// backlog is pending (|acc|>=64 -> STEP_DIV/2, |acc|>=256 -> STEP_DIV/4).
module cv_spinner_quad #(
    parameter int STEP_DIV = 256,
    parameter int ACC_W    = 10
) (
    input  logic              clk_sys,
    input  logic              reset,
    cv_spinner_quad_if.slave  bus
);

    localparam int CNT_W   = $clog2(STEP_DIV);
    localparam int ACC_MAX = 2 ** (ACC_W - 1) - 1;

    localparam logic [CNT_W-1:0]      RELOAD_SLOW = CNT_W'(STEP_DIV - 1);
`ifdef CV_SPIN_ACCEL_EN
    localparam logic [CNT_W-1:0]      RELOAD_MID  = CNT_W'(STEP_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]      RELOAD_FAST = CNT_W'((STEP_DIV / 4 > 0) ? STEP_DIV / 4 - 1 : 0);
`endif
    localparam logic signed [ACC_W+1:0] ONE_W     = (ACC_W + 2)'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Clamp to the symmetric range so the most negative code is never stored.
    function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W+1:0] v);
        logic signed [ACC_W+1:0] hi;
        logic signed [ACC_W+1:0] lo;
        hi = (ACC_W + 2)'(ACC_MAX);
        lo = -hi;
        if (v > hi)      sat_acc = hi[ACC_W-1:0];
        else if (v < lo) sat_acc = lo[ACC_W-1:0];
        else             sat_acc = v[ACC_W-1:0];
    endfunction

    // Gray-coded phase walk: positive 11->10->00->01->11, negative the reverse.
    function automatic logic [1:0] next_phase(input logic [1:0] q, input logic pos);
        case (q)
            2'b11:   next_phase = pos ? 2'b10 : 2'b01;
            2'b10:   next_phase = pos ? 2'b00 : 2'b11;
            2'b00:   next_phase = pos ? 2'b01 : 2'b10;
            default: next_phase = pos ? 2'b11 : 2'b00;
        endcase
    endfunction

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    tog_q, tog_d;
    logic [1:0]              quad_q, quad_d;
    logic                    step_q, step_d;
    logic                    dir_q, dir_d;
    logic                    pend_q, pend_d;

    logic                    ev_w;
    logic                    step_w;
    logic                    pos_w;
    logic signed [7:0]       delta_w;
    logic signed [ACC_W+1:0] sum_w;
    logic [CNT_W-1:0]        reload_w;
`ifdef CV_SPIN_ACCEL_EN
    logic [ACC_W-1:0]        mag_w;
`endif

    // Next-state: event detect, step decision, accumulator update and pacing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        quad_d  = quad_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        step_d  = 1'b0;
        tog_d   = bus.spinner_i[8];

        ev_w    = bus.spinner_i[8] ^ tog_q;
        delta_w = ev_w ? $signed(bus.spinner_i[7:0]) : 8'sd0;
        step_w  = bus.ce_i && (cnt_q == '0) && (acc_q != '0);
        pos_w   = !acc_q[ACC_W-1];

`ifdef CV_SPIN_ACCEL_EN
        // Backlog magnitude taken before this cycle's update, i.e. at the step edge.
        mag_w = acc_q[ACC_W-1] ? -acc_q : acc_q;
        if (mag_w >= ACC_W'(256))     reload_w = RELOAD_FAST;
        else if (mag_w >= ACC_W'(64)) reload_w = RELOAD_MID;
        else                          reload_w = RELOAD_SLOW;
`else
        reload_w = RELOAD_SLOW;
`endif

        // Event and step are folded into one update so a coinciding pair loses nothing.
        sum_w = {{2{acc_q[ACC_W-1]}}, acc_q} + {{(ACC_W - 6){delta_w[7]}}, delta_w};
        if (step_w) sum_w = pos_w ? (sum_w - ONE_W) : (sum_w + ONE_W);

        if (!bus.enable_i) begin
            // Detached: drop the backlog and park the pins; tog_q keeps tracking.
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
            quad_d  = 2'b11;
            pend_d  = 1'b0;
        end else begin
            acc_d  = sat_acc(sum_w);
            pend_d = (acc_d != '0);
            if (bus.ce_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (step_w) begin
                            cnt_d   = reload_w;
                            state_d = S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (cnt_q != '0)  cnt_d = cnt_q - CNT_W'(1);
                        else if (step_w)  cnt_d = reload_w;
                        else              state_d = S_IDLE;
                    end
                endcase
            end
            if (step_w) begin
                step_d = 1'b1;
                dir_d  = pos_w;
                quad_d = next_phase(quad_q, pos_w);
            end
        end
    end

    // State and registered outputs; reset re-captures the toggle to avoid a phantom event.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            tog_q   <= bus.spinner_i[8];
            quad_q  <= 2'b11;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            tog_q   <= tog_d;
            quad_q  <= quad_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.quad_o    = quad_q;
    assign bus.step_o    = step_q;
    assign bus.dir_o     = dir_q;
    assign bus.pending_o = pend_q;

endmodule
